uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer between the buart receiver and the J1 I/O read path.
- Drains buart with its valid/rd handshake one byte at a time and stores bytes in a show-ahead FIFO.
- Presents the head byte, an occupancy count and a sticky overflow flag to the CPU I/O decoder.
- CPU reads of the UART RX address pop the FIFO, so line bursts at high baud are no longer lost between CPU polls.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 by default).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_valid  input  1  buart rx byte available.
- uart_data  input  8  buart rx byte, stable while uart_valid=1.
- uart_rd  output  1  acknowledge strobe to buart; consumes the byte.
- cpu_rd  input  1  single-cycle pop strobe (I/O read of the RX data address).
- cpu_data  output  8  head-of-FIFO byte (show-ahead).
- avail  output  1  FIFO non-empty.
- count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  input  1  single-cycle clear of overflow.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, uart_rd=0, overflow=0. Storage array is not reset.
- Reset mid-operation discards all stored bytes immediately. Any byte still pending in buart is captured normally after release.
- Outputs are registered or direct decodes of registers; no combinational path from any input to any output.
- Capture: when uart_valid=1 and uart_rd=0, the block samples uart_data that cycle (a "push request"). It drives uart_rd=1 for exactly the following cycle, then 0.
  - uart_rd never stays high for two consecutive cycles.
  - While uart_rd=1, uart_valid is ignored, so the one-cycle lag in buart dropping valid cannot double-capture.
  - Minimum spacing between captures is 2 cycles.
- Push request when count<depth: byte written at wr_ptr, wr_ptr increments modulo depth, count+1. The byte is visible on cpu_data/avail the next cycle if the FIFO was empty.
- Push request when count==depth and no pop that cycle: byte dropped, uart_rd still pulsed (buart always drained), overflow<=1, pointers/count unchanged.
- Pop: cpu_rd=1 and count>0 → rd_ptr increments modulo depth, count-1. cpu_rd with count==0 is ignored (no pointer change, no error).
- Simultaneous push request and pop:
  - count>0 and <depth: both occur, count unchanged.
  - count==depth: the pop frees the slot and the push is accepted, count stays depth, no overflow.
  - count==0: pop ignored, push accepted, count becomes 1.
- cpu_data = storage[rd_ptr] when count>0, else 8'h00. Pointer wrap is seamless.
- avail = (count != 0).
- Overflow: set by any dropped byte, cleared by ovf_clr. Set and clear in the same cycle → set wins (overflow stays 1).
- Width rules: pointers are DEPTH_LOG2 bits and wrap naturally. count is DEPTH_LOG2+1 bits and never exceeds depth or goes below 0.

Test Plan:
- Reset then idle 10 cycles → count=0, avail=0, cpu_data=8'h00, uart_rd=0, overflow=0. Assert reset asynchronously mid-cycle with 5 bytes stored → count=0 before the next clk edge.
- buart model delivers 8'h41, 8'h42, 8'h43, each valid held until 1 cycle after uart_rd → exactly one uart_rd pulse per byte. Three pops → cpu_data 41,42,43, then avail=0 and cpu_data=00.
- Push 20 bytes 8'h00..8'h13 with no pops → count=16, overflow=1 after byte 8'h10, 20 uart_rd pulses. Pop 16 → bytes 00..0F in order, count=0; overflow remains 1 until ovf_clr.
- With count=16, push request and cpu_rd in the same cycle → count stays 16, overflow stays 0. Next 16 pops return original bytes 2..16 followed by the new byte.
- Empty FIFO, cpu_rd and push request of 8'h5A in the same cycle → count=1, cpu_data=5A the next cycle. Also cpu_rd on empty for 4 cycles → count stays 0.
- Stream 40 bytes with a pop every 3rd cycle and no overflow → all 40 bytes read back in order across ≥2 pointer wraps. ovf_clr pulsed in the same cycle as a drop → overflow=1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between buart, the RX FIFO and the J1 I/O read path.
// The master side drives the buart byte, the CPU pop strobe and the overflow clear.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  uart_valid;
    logic [7:0]            uart_data;
    logic                  uart_rd;
    logic                  cpu_rd;
    logic [7:0]            cpu_data;
    logic                  avail;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output uart_valid, uart_data, cpu_rd, ovf_clr,
        input  uart_rd, cpu_data, avail, count, overflow
    );

    modport slave (
        input  uart_valid, uart_data, cpu_rd, ovf_clr,
        output uart_rd, cpu_data, avail, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between buart and the CPU: one-cycle ack strobe per captured byte,
// show-ahead head byte, occupancy count and sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  uart_rd_r;
    logic                  overflow_r;

    logic push_req;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // valid is ignored while the ack is out, covering buart's one-cycle lag in dropping it
    always_comb begin
        push_req = bus.uart_valid && !uart_rd_r;
        full     = (count_r == FULL_COUNT);
        pop      = bus.cpu_rd && (count_r != '0);
        accept   = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            uart_rd_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            uart_rd_r <= push_req;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            // a drop in the same cycle as a clear keeps the flag set
            if (drop)
                overflow_r <= 1'b1;
            else if (bus.ovf_clr)
                overflow_r <= 1'b0;
        end
    end

    // When full, a write lands in the slot being popped; rd_ptr moves past it on the same edge.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= bus.uart_data;
    end

    assign bus.uart_rd  = uart_rd_r;
    assign bus.count    = count_r;
    assign bus.avail    = (count_r != '0);
    assign bus.overflow = overflow_r;
    assign bus.cpu_data = (count_r != '0) ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: buart delivery model, CPU pops, overflow and wrap cases.
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   rd_pulses;
    int   double_rd;
    logic prev_rd;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.uart_rd === 1'b1) begin
            rd_pulses = rd_pulses + 1;
            if (prev_rd === 1'b1)
                double_rd = double_rd + 1;
        end
        prev_rd = bus.uart_rd;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // buart model: valid held through the ack cycle, dropped one cycle after uart_rd
    task automatic deliver(input logic [7:0] b);
        int unsigned n;
        n = 0;
        bus.uart_valid = 1'b1;
        bus.uart_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (bus.uart_rd !== 1'b1 && n < 8);
        chk("deliver_ack", {15'd0, bus.uart_rd}, 16'd1);
        @(negedge clk);
        bus.uart_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {8'd0, bus.cpu_data}, {8'd0, exp});
        bus.cpu_rd = 1'b1;
        @(negedge clk);
        bus.cpu_rd = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int p0;
        int got;
        total = 0; passed = 0; rd_pulses = 0; double_rd = 0; prev_rd = 1'b0;
        bus.uart_valid = 1'b0; bus.uart_data = 8'h00; bus.cpu_rd = 1'b0; bus.ovf_clr = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(10);
        chk("rst_count",    {11'd0, bus.count}, 16'd0);
        chk("rst_avail",    {15'd0, bus.avail}, 16'd0);
        chk("rst_cpu_data", {8'd0, bus.cpu_data}, 16'h00);
        chk("rst_uart_rd",  {15'd0, bus.uart_rd}, 16'd0);
        chk("rst_overflow", {15'd0, bus.overflow}, 16'd0);

        // asynchronous reset with five bytes stored
        for (int unsigned i = 0; i < 5; i++) deliver(8'hE0 + 8'(i));
        chk("pre_async_count", {11'd0, bus.count}, 16'd5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_rst_count", {11'd0, bus.count}, 16'd0);
        chk("async_rst_avail", {15'd0, bus.avail}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // three bytes, one ack each
        p0 = rd_pulses;
        deliver(8'h41); deliver(8'h42); deliver(8'h43);
        chk("abc_pulses", 16'(rd_pulses - p0), 16'd3);
        chk("abc_count", {11'd0, bus.count}, 16'd3);
        pop_chk("abc_pop0", 8'h41);
        pop_chk("abc_pop1", 8'h42);
        pop_chk("abc_pop2", 8'h43);
        chk("abc_avail", {15'd0, bus.avail}, 16'd0);
        chk("abc_cpu_data", {8'd0, bus.cpu_data}, 16'h00);

        // 20 bytes into a 16-deep FIFO
        p0 = rd_pulses;
        for (int unsigned i = 0; i < 16; i++) deliver(8'(i));
        chk("fill_count", {11'd0, bus.count}, 16'd16);
        chk("fill_ovf_before", {15'd0, bus.overflow}, 16'd0);
        deliver(8'h10);
        chk("fill_ovf_after", {15'd0, bus.overflow}, 16'd1);
        for (int unsigned i = 17; i < 20; i++) deliver(8'(i));
        chk("fill_pulses", 16'(rd_pulses - p0), 16'd20);
        chk("fill_count_hold", {11'd0, bus.count}, 16'd16);
        for (int unsigned i = 0; i < 16; i++) pop_chk("fill_pop", 8'(i));
        chk("drain_count", {11'd0, bus.count}, 16'd0);
        chk("drain_ovf_sticky", {15'd0, bus.overflow}, 16'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", {15'd0, bus.overflow}, 16'd0);

        // full FIFO: simultaneous push and pop
        for (int unsigned i = 1; i <= 16; i++) deliver(8'(i));
        bus.uart_valid = 1'b1; bus.uart_data = 8'hAA; bus.cpu_rd = 1'b1;
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        chk("full_pp_ack", {15'd0, bus.uart_rd}, 16'd1);
        chk("full_pp_count", {11'd0, bus.count}, 16'd16);
        chk("full_pp_ovf", {15'd0, bus.overflow}, 16'd0);
        @(negedge clk);
        bus.uart_valid = 1'b0;
        for (int unsigned i = 2; i <= 16; i++) pop_chk("full_pp_pop", 8'(i));
        pop_chk("full_pp_new", 8'hAA);
        chk("full_pp_empty", {11'd0, bus.count}, 16'd0);

        // empty FIFO: simultaneous push and pop
        bus.uart_valid = 1'b1; bus.uart_data = 8'h5A; bus.cpu_rd = 1'b1;
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        chk("empty_pp_count", {11'd0, bus.count}, 16'd1);
        chk("empty_pp_data", {8'd0, bus.cpu_data}, 16'h5A);
        @(negedge clk);
        bus.uart_valid = 1'b0;
        pop_chk("empty_pp_pop", 8'h5A);
        bus.cpu_rd = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("empty_rd_count", {11'd0, bus.count}, 16'd0);
        end
        bus.cpu_rd = 1'b0;
        idle(1);

        // 40-byte stream with a pop every third cycle
        got = 0;
        fork
            begin
                for (int unsigned i = 0; i < 40; i++) deliver(8'h80 + 8'(i));
            end
            begin
                for (int unsigned cyc = 0; cyc < 400 && got < 40; cyc++) begin
                    @(negedge clk);
                    bus.cpu_rd = 1'b0;
                    if (cyc % 3 == 0 && bus.avail === 1'b1) begin
                        chk("stream_pop", {8'd0, bus.cpu_data}, {8'd0, 8'h80 + 8'(got)});
                        bus.cpu_rd = 1'b1;
                        got++;
                    end
                end
                @(negedge clk);
                bus.cpu_rd = 1'b0;
            end
        join
        chk("stream_got", 16'(got), 16'd40);
        chk("stream_ovf", {15'd0, bus.overflow}, 16'd0);
        chk("stream_empty", {11'd0, bus.count}, 16'd0);

        // drop and clear in the same cycle: set wins
        for (int unsigned i = 0; i < 16; i++) deliver(8'hC0 + 8'(i));
        bus.uart_valid = 1'b1; bus.uart_data = 8'hFF; bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("setclr_ovf", {15'd0, bus.overflow}, 16'd1);
        chk("setclr_count", {11'd0, bus.count}, 16'd16);
        @(negedge clk);
        bus.uart_valid = 1'b0;
        pop_chk("setclr_head", 8'hC0);

        chk("no_double_ack", 16'(double_rd), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
